bram_scan_seq: RTL and testbench
================================

# bram_scan_seq

Sequencer for the PL-side port of the 2048×32 accelerator BRAM. Implements the PS start/done four-phase handshake, streams a configurable word range from the BRAM to a reduction operator, and writes the operator's result back to a configured BRAM word. It splits the control path out of single-purpose accelerators so that any scan-and-reduce operator can sit behind one shared controller.

## Interface
- ADDR_W, 11, BRAM word-address width (depth 2^ADDR_W)
- DATA_W, 32, BRAM data width
---
- clk  in  1  single clock; BRAM PL port and operator share it
- reset  in  1  synchronous, active-high
- ps_control  in  32  [0] start (level), [1] abort; other bits ignored
- cfg_first  in  ADDR_W  first word index; sampled on accepted start
- cfg_last  in  ADDR_W  last word index, inclusive; sampled on accepted start
- cfg_wb_addr  in  ADDR_W  writeback word index; sampled on accepted start
- pl_status  out  32  [0] done, [1] busy, [2] cfg_error, [3] aborted; other bits 0
- mem_en  out  1  BRAM port enable
- mem_we  out  1  BRAM write enable, whole word
- mem_addr  out  ADDR_W  BRAM word address
- mem_wrdata  out  DATA_W  BRAM write data
- mem_rddata  in  DATA_W  BRAM read data, 1-cycle latency after mem_en
- op_valid  out  1  op_data valid this cycle
- op_first  out  1  qualifies the first beat of a scan
- op_last  out  1  qualifies the final beat of a scan
- op_data  out  DATA_W  mem_rddata passed through combinationally
- op_result  in  DATA_W  operator result; registered by the operator, stable 1 cycle after the op_last beat

## Operation
- States: IDLE, READ, DRAIN, WB, DONE.
- IDLE: accepts start when ps_control[0]=1 at a clock edge. On acceptance, latches cfg_*, clears status bits [3:2] and sets busy.
  - If cfg_first > cfg_last: sets cfg_error and goes to DONE. No BRAM access, no op beats.
  - Otherwise goes to READ.
- READ: mem_en=1, mem_we=0. mem_addr runs from first to last, one address per cycle. After the cycle that issues last, goes to DRAIN.
- DRAIN: one cycle with no BRAM access. The final beat is delivered, then the block goes to WB.
- WB: one cycle. mem_en=1, mem_we=1, mem_addr=wb_addr, mem_wrdata=op_result. Then goes to DONE.
- DONE: done=1, busy=0. Stays in DONE while start=1. Returns to IDLE on the first edge where start=0; done clears on that same edge.
- Beat pipeline: op_valid is mem_en&~mem_we delayed 1 cycle. op_first and op_last are the registered flags for the issued addresses equal to first and last.
- N = last−first+1 (1..2048). The address counter is ADDR_W+1 bits wide so a full 0..2047 scan never wraps early.
- Abort: ps_control[1]=1 in READ or DRAIN → aborted=1, go to DONE.
  - No WB cycle.
  - A beat already in flight still emits op_valid the next cycle, with op_last=0.
  - Abort is ignored in IDLE, WB and DONE.
- Start and abort both high in IDLE: start is accepted, then the run aborts on the first READ cycle.
- Reset at any point: IDLE, next cycle has no BRAM write, status cleared.

## Timing
- Reset value of every output is 0, including the pl_status bits, mem_* and op_*.
- Start accepted at edge S:
  - mem addresses are issued in cycles S+1..S+N
  - op_valid is high in cycles S+2..S+N+1
  - WB cycle is S+N+2
  - done=1 from S+N+3
- Full 2048-word scan: done at S+2051.
- cfg_error path: done=1 from S+1.
- All outputs are registered except op_data.
- Throughput is one word per cycle with no bubbles.

## Structure
- Package bram_seq_pkg holds:
  - state enum
  - ps_control bit indices: START=0, ABORT=1
  - pl_status bit indices: DONE=0, BUSY=1, CFG_ERR=2, ABORTED=3
- No sub-module; a single module. The BRAM and the operator live outside the block.

## Test plan
- Full range: first=0, last=2047, wb=0, BRAM = random data with 0xFFFFFFFF at word 2047, max operator attached → 2048 beats, op_first at word 0 only, op_last at word 2047 only, word 0 reads 0xFFFFFFFF, done at S+2051.
- Sub-range: first=5, last=9, wb=100 → addresses 5..9, 5 beats, write to 100 at S+7, done at S+8.
- Single word: first=last=7 → one beat with op_first=op_last=1, WB at S+3.
- Config error: first=10, last=3 → pl_status=0x5 at S+1, mem_en never asserted.
- Abort at S+4 of a 0..2047 scan → aborted=1, no mem_we, done stays high while start=1, returns to IDLE one edge after start drops.
- Reset asserted mid-READ → all outputs 0 on the next cycle, no write. A new start then runs normally.

Source files
------------

// File: rtl/bram_seq_pkg.sv
// Shared types and bit positions for the BRAM scan-and-reduce sequencer.
package bram_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WB,
    ST_DONE
  } state_e;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_ABORT = 1;

  localparam int unsigned STAT_DONE    = 0;
  localparam int unsigned STAT_BUSY    = 1;
  localparam int unsigned STAT_CFG_ERR = 2;
  localparam int unsigned STAT_ABORTED = 3;

endpackage

// File: rtl/bram_scan_seq.sv
// Scan-and-reduce controller: streams BRAM words [first..last] to an external
// operator, then writes the operator result back to wb_addr.
module bram_scan_seq
  import bram_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ps_control,
  input  logic [ADDR_W-1:0] cfg_first,
  input  logic [ADDR_W-1:0] cfg_last,
  input  logic [ADDR_W-1:0] cfg_wb_addr,
  output logic [31:0]       pl_status,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrdata,
  input  logic [DATA_W-1:0] mem_rddata,
  output logic              op_valid,
  output logic              op_first,
  output logic              op_last,
  output logic [DATA_W-1:0] op_data,
  input  logic [DATA_W-1:0] op_result
);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] wb_q, wb_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              op_valid_q, op_valid_d;
  logic              op_first_q, op_first_d;
  logic              op_last_q, op_last_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              cfg_err_q, cfg_err_d;
  logic              aborted_q, aborted_d;

  logic start, abort, rd_issue;
  logic ctrl_unused;

  assign start       = ps_control[CTRL_START];
  assign abort       = ps_control[CTRL_ABORT];
  assign ctrl_unused = ^ps_control[31:2];
  assign rd_issue    = mem_en_q & ~mem_we_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    last_d     = last_q;
    wb_d       = wb_q;
    mem_addr_d = mem_addr_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    done_d     = done_q;
    busy_d     = busy_q;
    cfg_err_d  = cfg_err_q;
    aborted_d  = aborted_q;
    // Beat flags follow the read issued last cycle, one cycle behind the address.
    op_valid_d = rd_issue;
    op_first_d = rd_issue && (mem_addr_q == first_q);
    op_last_d  = rd_issue && (mem_addr_q == last_q);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          first_d   = cfg_first;
          last_d    = cfg_last;
          wb_d      = cfg_wb_addr;
          cfg_err_d = 1'b0;
          aborted_d = 1'b0;
          if (cfg_first > cfg_last) begin
            cfg_err_d = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_DONE;
          end else begin
            busy_d     = 1'b1;
            cnt_d      = {1'b0, cfg_first};
            mem_addr_d = cfg_first;
            mem_en_d   = 1'b1;
            state_d    = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (abort) begin
          aborted_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          op_last_d = 1'b0;
          state_d   = ST_DONE;
        end else if (cnt_q == {1'b0, last_q}) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          mem_addr_d = cnt_d[ADDR_W-1:0];
          mem_en_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          aborted_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_DONE;
        end else begin
          mem_en_d   = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = wb_q;
          state_d    = ST_WB;
        end
      end
      ST_WB: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      first_q    <= '0;
      last_q     <= '0;
      wb_q       <= '0;
      mem_addr_q <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      op_valid_q <= 1'b0;
      op_first_q <= 1'b0;
      op_last_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      last_q     <= last_d;
      wb_q       <= wb_d;
      mem_addr_q <= mem_addr_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      op_valid_q <= op_valid_d;
      op_first_q <= op_first_d;
      op_last_q  <= op_last_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      cfg_err_q  <= cfg_err_d;
      aborted_q  <= aborted_d;
    end
  end

  assign pl_status = {28'd0, aborted_q, cfg_err_q, busy_q, done_q};
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign op_valid  = op_valid_q;
  assign op_first  = op_first_q;
  assign op_last   = op_last_q;
  assign op_data   = mem_rddata;
  // The operator result only settles in the WB cycle itself, so it cannot be
  // registered here; gating by the registered write strobe keeps it 0 otherwise.
  assign mem_wrdata = mem_we_q ? op_result : '0;

endmodule

// File: tb/tb_bram_scan_seq.sv
// Directed bench for bram_scan_seq with a BRAM model and a max-reduction operator.
module tb_bram_scan_seq;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 2048;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       ps_control;
  logic [ADDR_W-1:0] cfg_first, cfg_last, cfg_wb_addr;
  logic [31:0]       pl_status;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wrdata, mem_rddata;
  logic              op_valid, op_first, op_last;
  logic [DATA_W-1:0] op_data, op_result;

  bram_scan_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps_control (ps_control),
    .cfg_first  (cfg_first),
    .cfg_last   (cfg_last),
    .cfg_wb_addr(cfg_wb_addr),
    .pl_status  (pl_status),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wrdata (mem_wrdata),
    .mem_rddata (mem_rddata),
    .op_valid   (op_valid),
    .op_first   (op_first),
    .op_last    (op_last),
    .op_data    (op_data),
    .op_result  (op_result)
  );

  always #5 clk = ~clk;

  // BRAM model, read-first, 1-cycle read latency; init_req preloads random data.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              init_req;
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i == DEPTH - 1) ? 32'hFFFF_FFFF : $urandom;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wrdata;
      mem_rddata <= mem[mem_addr];
    end
  end

  // Max-reduction operator.
  logic [DATA_W-1:0] acc;
  always @(posedge clk) begin
    if (reset) acc <= '0;
    else if (op_valid) acc <= (op_first || op_data > acc) ? op_data : acc;
  end
  assign op_result = acc;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  int unsigned rel, done_rel, wb_rel, en_cnt, beats, firsts, lasts;
  int unsigned first_pos, last_pos, seq_err, data_err, we_cnt;
  logic [31:0] status_at_done, wb_data_seen;
  logic [ADDR_W-1:0] wb_addr_seen;

  function automatic logic [31:0] range_max(input int unsigned f, input int unsigned l);
    logic [31:0] m;
    m = mem[f];
    for (int unsigned i = f; i <= l; i++) if (mem[i] > m) m = mem[i];
    return m;
  endfunction

  task automatic run(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                     input logic [ADDR_W-1:0] w, input int unsigned abort_rel,
                     input bit abort_at_start, input int unsigned limit);
    logic [ADDR_W-1:0] idx;
    @(negedge clk);
    cfg_first   = f;
    cfg_last    = l;
    cfg_wb_addr = w;
    ps_control  = {30'd0, abort_at_start, 1'b1};
    rel = 0; done_rel = 0; wb_rel = 0; en_cnt = 0; beats = 0; firsts = 0; lasts = 0;
    first_pos = 0; last_pos = 0; seq_err = 0; data_err = 0; we_cnt = 0;
    status_at_done = '0; wb_data_seen = '0; wb_addr_seen = '0;
    @(posedge clk);
    while (done_rel == 0 && rel < limit) begin
      @(negedge clk);
      rel++;
      if (mem_en && !mem_we) begin
        en_cnt++;
        if (mem_addr != ADDR_W'(f + en_cnt - 1) || rel != en_cnt) seq_err++;
      end
      if (mem_we) begin
        we_cnt++;
        wb_rel       = rel;
        wb_addr_seen = mem_addr;
        wb_data_seen = mem_wrdata;
      end
      if (op_valid) begin
        idx = ADDR_W'(f + beats);
        if (op_data !== mem[idx]) data_err++;
        if (rel != beats + 2) seq_err++;
        if (op_first) begin firsts++; first_pos = beats; end
        if (op_last)  begin lasts++;  last_pos  = beats; end
        beats++;
      end
      if (pl_status[0]) begin
        done_rel       = rel;
        status_at_done = pl_status;
      end
      if (abort_rel != 0 && rel == abort_rel) ps_control[1] = 1'b1;
    end
    ps_control[1] = 1'b0;
    check("done_in_time", 32'(done_rel != 0), 32'd1);
  endtask

  task automatic finish_run(input logic [31:0] exp_hold, input logic [31:0] exp_idle);
    repeat (3) @(negedge clk);
    check("done_held", pl_status, exp_hold);
    ps_control[0] = 1'b0;
    @(negedge clk);
    check("idle_status", pl_status, exp_idle);
  endtask

  logic [31:0] emax;

  initial begin
    reset       = 1'b1;
    init_req    = 1'b1;
    ps_control  = '0;
    cfg_first   = '0;
    cfg_last    = '0;
    cfg_wb_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_status", pl_status, 32'd0);
    check("rst_mem", 32'({mem_en, mem_we, mem_addr}) | mem_wrdata, 32'd0);
    check("rst_op", 32'({op_valid, op_first, op_last}), 32'd0);
    init_req = 1'b0;
    reset    = 1'b0;

    // Full 0..2047 scan, max written back to word 0.
    run(11'd0, 11'd2047, 11'd0, 0, 1'b0, 2100);
    check("full_en", en_cnt, 2048);
    check("full_beats", beats, 2048);
    check("full_seq", seq_err, 0);
    check("full_data", data_err, 0);
    check("full_firsts", firsts, 1);
    check("full_first_pos", first_pos, 0);
    check("full_lasts", lasts, 1);
    check("full_last_pos", last_pos, 2047);
    check("full_we", we_cnt, 1);
    check("full_wb_rel", wb_rel, 2050);
    check("full_wb_addr", 32'(wb_addr_seen), 32'd0);
    check("full_wb_data", wb_data_seen, 32'hFFFF_FFFF);
    check("full_done_rel", done_rel, 2051);
    check("full_status", status_at_done, 32'h1);
    finish_run(32'h1, 32'h0);
    check("full_mem0", mem[0], 32'hFFFF_FFFF);

    // Sub-range 5..9 -> word 100.
    emax = range_max(5, 9);
    run(11'd5, 11'd9, 11'd100, 0, 1'b0, 50);
    check("sub_en", en_cnt, 5);
    check("sub_beats", beats, 5);
    check("sub_seq", seq_err, 0);
    check("sub_data", data_err, 0);
    check("sub_last_pos", last_pos, 4);
    check("sub_wb_rel", wb_rel, 7);
    check("sub_wb_addr", 32'(wb_addr_seen), 32'd100);
    check("sub_wb_data", wb_data_seen, emax);
    check("sub_done_rel", done_rel, 8);
    finish_run(32'h1, 32'h0);
    check("sub_mem100", mem[100], emax);

    // Single word 7.
    emax = mem[7];
    run(11'd7, 11'd7, 11'd300, 0, 1'b0, 50);
    check("one_beats", beats, 1);
    check("one_firsts", firsts, 1);
    check("one_lasts", lasts, 1);
    check("one_wb_rel", wb_rel, 3);
    check("one_wb_data", wb_data_seen, emax);
    check("one_done_rel", done_rel, 4);
    finish_run(32'h1, 32'h0);

    // Config error: first > last.
    run(11'd10, 11'd3, 11'd0, 0, 1'b0, 20);
    check("err_done_rel", done_rel, 1);
    check("err_status", status_at_done, 32'h5);
    check("err_en", en_cnt + we_cnt + beats, 0);
    finish_run(32'h5, 32'h4);

    // Abort sampled at edge S+4 of a full scan.
    run(11'd0, 11'd2047, 11'd0, 4, 1'b0, 50);
    check("abt_en", en_cnt, 4);
    check("abt_beats", beats, 4);
    check("abt_lasts", lasts, 0);
    check("abt_we", we_cnt, 0);
    check("abt_done_rel", done_rel, 5);
    check("abt_status", status_at_done, 32'h9);
    finish_run(32'h9, 32'h8);

    // Start and abort together in IDLE.
    run(11'd0, 11'd0, 11'd0, 0, 1'b1, 20);
    check("sa_en", en_cnt, 1);
    check("sa_beats", beats, 1);
    check("sa_lasts", lasts, 0);
    check("sa_we", we_cnt, 0);
    check("sa_done_rel", done_rel, 2);
    check("sa_status", status_at_done, 32'h9);
    finish_run(32'h9, 32'h8);

    // Reset in the middle of a read scan, then a normal run.
    @(negedge clk);
    cfg_first   = 11'd0;
    cfg_last    = 11'd2047;
    cfg_wb_addr = 11'd0;
    ps_control  = 32'h1;
    @(posedge clk);
    repeat (10) @(negedge clk);
    reset      = 1'b1;
    ps_control = '0;
    @(negedge clk);
    check("mrst_status", pl_status, 32'd0);
    check("mrst_mem", 32'({mem_en, mem_we, mem_addr}) | mem_wrdata, 32'd0);
    check("mrst_op", 32'({op_valid, op_first, op_last}), 32'd0);
    reset = 1'b0;
    emax = range_max(20, 22);
    run(11'd20, 11'd22, 11'd200, 0, 1'b0, 50);
    check("post_beats", beats, 3);
    check("post_seq", seq_err, 0);
    check("post_wb_data", wb_data_seen, emax);
    check("post_done_rel", done_rel, 6);
    finish_run(32'h1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
